pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 16-bit windowed-register core (ID=stage1, EX=2, MEM=3, WB=4).
//  Sits beside the forwarding unit. Handles the cases forwarding cannot cover:
//   - load-use stalls
//   - taken-branch flush
//   - data-memory wait freeze
//   - memory-timeout halt
//  Drives the write-enable and flush controls of the PC and pipeline registers.
// PARAMETERS
//  BOOT_CYCLES  4  cycles spent flushing after reset deasserts (>=1)
//  MEM_TIMEOUT  8  max MEM_WAIT cycles before halting; 0 disables the watchdog
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  inst1        in   16  instruction in ID
//  inst2        in   16  instruction in EX
//  inst3        in   16  instruction in MEM
//  window1      in   2   register window of inst1
//  window2      in   2   register window of inst2
//  br_taken     in   1   ID branch compare result; valid when inst1 is a branch
//  mem_busy     in   1   data memory not ready this cycle
//  perf_clr     in   1   synchronous clear of perf counters
//  pc_we        out  1   PC update enable
//  ifid_we      out  1   IF/ID register enable
//  ifid_flush   out  1   IF/ID register loads a bubble
//  idex_we      out  1   ID/EX register enable
//  idex_flush   out  1   ID/EX register loads a bubble
//  exmem_we     out  1   EX/MEM register enable
//  memwb_flush  out  1   MEM/WB register loads a bubble
//  halted       out  1   core halted
//  mem_err      out  1   sticky memory-timeout flag
//  state        out  2   FSM state: BOOT=0, RUN=1, MEM_WAIT=2, HALT=3
//  stall_cnt    out  16  perf counter (see CONFIGURATION)
//  flush_cnt    out  16  perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Decode:
//   - phys reg = ({window,1'b0} + field) mod 8, using inst[11:10] for Rx and inst[9:8] for Ry.
//     Example: window 3 with field 3 gives phys 1.
//   - Opcodes: load = [15:12]==0000; store = 0001; branch = 0100; ALU = bit15 set.
//   - Source use by inst1: ALU, store and branch read Rx and Ry; load reads Ry only.
//  Hazard:
//   - ld_use = inst2 is a load AND (phys Rx2 matches a phys source of inst1).
//   - Rx2 is decoded with window2; inst1 sources are decoded with window1.
//  Reset / BOOT:
//   - Outputs during and after reset: pc_we=0, ifid_we=0, idex_we=0, exmem_we=0,
//     ifid_flush=1, idex_flush=1, memwb_flush=1, halted=0, mem_err=0, state=BOOT, counters=0.
//   - BOOT holds these outputs for BOOT_CYCLES cycles, then moves to RUN.
//  RUN: outputs are combinational from state and inputs, in priority order:
//   1. Memory wait (inst3 is load/store AND mem_busy):
//      pc_we=ifid_we=idex_we=exmem_we=0, memwb_flush=1; next state MEM_WAIT; wait counter=0.
//   2. ld_use: pc_we=ifid_we=0, idex_flush=1 (one bubble); state stays RUN.
//   3. inst1 is a branch AND br_taken: ifid_flush=1, pc_we=1 (target loads).
//      A branch with ld_use stalls first; the flush is taken on re-evaluation.
//   4. Otherwise: all enables 1, all flushes 0.
//  MEM_WAIT:
//   - While mem_busy: freeze as in RUN case 1; wait counter +1.
//   - If mem_busy AND counter==MEM_TIMEOUT-1 AND MEM_TIMEOUT!=0: next state HALT.
//   - When mem_busy=0: outputs evaluated exactly as RUN cases 2-4; next state RUN.
//  HALT:
//   - All enables 0, all flushes 0, halted=1, mem_err=1.
//   - Exits only via rst.
//  Reset asserted in any state, mid-operation: immediate return to BOOT values; mem_err clears.
// CONFIGURATION
//  Macro PIPE_PERF_CNT_EN.
//  Defined:
//   - stall_cnt +1 each RUN/MEM_WAIT cycle with pc_we=0.
//   - flush_cnt +1 each cycle a taken branch asserts ifid_flush.
//   - Both counters saturate at 16'hFFFF.
//   - perf_clr zeroes both counters and wins over a same-cycle increment.
//  Not defined: stall_cnt and flush_cnt tied to 0; perf_clr ignored.
// STRUCTURE
//  Package pipe_pkg: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH), state enum and
//  encodings, phys_reg() function.
//  Sub-module hz_detect: combinational ld_use decode.
//  FSM, wait counter, boot counter and perf counters stay in the top level.
// TESTING
//  T1 reset, BOOT_CYCLES=4 -> pc_we=0 for 4 cycles after rst falls; 5th cycle pc_we=1, state=1.
//  T2 inst2=16'h0400, window2=0; inst1=16'h8100, window1=0
//     -> one cycle pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1.
//  T3 inst2=16'h0C00, window2=3; inst1=16'h8100, window1=0 -> ld_use asserted (wrap to phys 1).
//  T4 inst1=16'h4000, br_taken=1, inst2=16'h8000 -> ifid_flush=1, pc_we=1, flush_cnt=1.
//     Repeat with inst2=16'h0000 -> stall, ifid_flush=0.
//  T5 inst3=16'h1000, mem_busy=1 for 3 cycles -> freeze 3 cycles, state=2, then RUN.
//     mem_busy held 9 cycles with MEM_TIMEOUT=8 -> state=3, mem_err=1 in cycle 10.
//  T6 rst pulse while in MEM_WAIT or HALT -> BOOT values, mem_err=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: opcodes, FSM state
// encodings and windowed-register decode helpers.
package pipe_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_BRANCH = 4'b0100;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // Physical register = (2*window + field) mod 8; the 3-bit sum wraps naturally.
    function automatic logic [2:0] phys_reg(input logic [1:0] window, input logic [1:0] field);
        return {window, 1'b0} + {1'b0, field};
    endfunction

    // Loads and stores are the only instructions that touch data memory.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-state inputs and pipeline-register controls of the hazard
// sequencer. The master side drives instructions and status, the slave
// side (the sequencer) drives enables, flushes and status outputs.
interface pipe_hazard_ctrl_if;

    logic [15:0] inst1;
    logic [15:0] inst2;
    logic [15:0] inst3;
    logic [1:0]  window1;
    logic [1:0]  window2;
    logic        br_taken;
    logic        mem_busy;
    logic        perf_clr;

    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_flush;
    logic        exmem_we;
    logic        memwb_flush;
    logic        halted;
    logic        mem_err;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output inst1, inst2, inst3, window1, window2, br_taken, mem_busy, perf_clr,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush,
               halted, mem_err, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  inst1, inst2, inst3, window1, window2, br_taken, mem_busy, perf_clr,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush,
               halted, mem_err, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hz_detect.sv
// Load-use hazard decode: a load in EX whose destination (Rx) is a
// source of the instruction in ID. Purely combinational.
module hz_detect
    import pipe_pkg::*;
(
    input  logic [15:0] inst1,
    input  logic [1:0]  window1,
    input  logic [15:0] inst2,
    input  logic [1:0]  window2,
    output logic        ld_use
);

    logic [3:0] op1;
    logic       reads_rx;
    logic       reads_ry;
    logic       inst2_load;
    logic [2:0] rx1;
    logic [2:0] ry1;
    logic [2:0] rx2;
    logic       unused_bits;

    assign op1        = inst1[15:12];
    // ALU, store and branch read both fields; a load reads only its base Ry.
    assign reads_rx   = inst1[15] | (op1 == OP_STORE) | (op1 == OP_BRANCH);
    assign reads_ry   = reads_rx | (op1 == OP_LOAD);
    assign inst2_load = (inst2[15:12] == OP_LOAD);

    assign rx1 = phys_reg(window1, inst1[11:10]);
    assign ry1 = phys_reg(window1, inst1[9:8]);
    assign rx2 = phys_reg(window2, inst2[11:10]);

    assign ld_use = inst2_load & ((reads_rx & (rx1 == rx2)) | (reads_ry & (ry1 == rx2)));

    assign unused_bits = ^{inst1[7:0], inst2[9:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes, data-memory
// wait freeze and memory-timeout halt for the 16-bit windowed core.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [15:0] BOOT_LAST = 16'(BOOT_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam bit          WDOG_EN   = (MEM_TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [15:0] boot_cnt;
    logic [15:0] wait_cnt;
    logic        ld_use;
    logic        inst1_taken;
    logic        inst3_mem;
    logic        r_pc_we, r_ifid_we, r_ifid_flush, r_idex_flush;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush;
    logic        halted, mem_err;
    logic        wait_clr, wait_inc, br_flush;
    logic        unused_inst3;

    hz_detect u_hz (
        .inst1   (bus.inst1),
        .window1 (bus.window1),
        .inst2   (bus.inst2),
        .window2 (bus.window2),
        .ld_use  (ld_use)
    );

    assign inst1_taken  = (bus.inst1[15:12] == OP_BRANCH) & bus.br_taken;
    assign inst3_mem    = is_mem_op(bus.inst3[15:12]);
    assign unused_inst3 = ^bus.inst3[11:0];

    // Non-freeze controls: load-use stall beats a taken branch, so a branch
    // waiting on a load is flushed only once it is re-evaluated.
    always_comb begin
        r_pc_we      = 1'b1;
        r_ifid_we    = 1'b1;
        r_ifid_flush = 1'b0;
        r_idex_flush = 1'b0;
        if (ld_use) begin
            r_pc_we      = 1'b0;
            r_ifid_we    = 1'b0;
            r_idex_flush = 1'b1;
        end else if (inst1_taken) begin
            r_ifid_flush = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    // Boot-length and memory-wait counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (state_q == ST_BOOT) boot_cnt <= boot_cnt + 16'd1;
            if (wait_clr)           wait_cnt <= '0;
            else if (wait_inc)      wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Next-state and pipeline-control decode.
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        mem_err     = 1'b0;
        wait_clr    = 1'b0;
        wait_inc    = 1'b0;
        br_flush    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                memwb_flush = 1'b1;
                if (boot_cnt == BOOT_LAST) state_d = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                // In RUN the freeze starts on a memory op; once waiting, busy alone holds it.
                if (bus.mem_busy && (inst3_mem || state_q == ST_MEM_WAIT)) begin
                    memwb_flush = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d  = ST_MEM_WAIT;
                        wait_clr = 1'b1;
                    end else begin
                        wait_inc = 1'b1;
                        if (WDOG_EN && wait_cnt == WAIT_LAST) state_d = ST_HALT;
                    end
                end else begin
                    pc_we      = r_pc_we;
                    ifid_we    = r_ifid_we;
                    ifid_flush = r_ifid_flush;
                    idex_we    = 1'b1;
                    idex_flush = r_idex_flush;
                    exmem_we   = 1'b1;
                    br_flush   = r_ifid_flush;
                    state_d    = ST_RUN;
                end
            end
            ST_HALT: begin
                halted  = 1'b1;
                mem_err = 1'b1;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_we    = exmem_we;
    assign bus.memwb_flush = memwb_flush;
    assign bus.halted      = halted;
    assign bus.mem_err     = mem_err;
    assign bus.state       = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic        stall_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign stall_evt = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_we;

    // Saturating stall/flush counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (bus.perf_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt) stall_q <= sat_inc(stall_q);
            if (br_flush)  flush_q <= sat_inc(flush_q);
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    logic unused_perf;
    assign unused_perf   = bus.perf_clr ^ br_flush;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int BOOT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 8;
`ifdef PIPE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush;
        logic        halted, mem_err;
        logic [1:0]  state;
        logic [15:0] stall_cnt, flush_cnt;
    } obs_t;

    // Model state: mode 0=boot,1=run,2=waiting on memory,3=halted.
    int m_mode      = 0;
    int m_boot_left = BOOT_CYCLES;
    int m_wait_n    = 0;
    int m_stall     = 0;
    int m_flush     = 0;

    function automatic int phys(input int w, input int f);
        return (w * 2 + f) % 8;
    endfunction

    function automatic bit hazard();
        int  op1, rx1, ry1, rx2;
        bit  rd_x, rd_y;
        if (bus.inst2[15:12] != 4'd0) return 0;
        op1  = int'(bus.inst1[15:12]);
        rd_x = bus.inst1[15] || op1 == 1 || op1 == 4;
        rd_y = rd_x || op1 == 0;
        rx1  = phys(int'(bus.window1), int'(bus.inst1[11:10]));
        ry1  = phys(int'(bus.window1), int'(bus.inst1[9:8]));
        rx2  = phys(int'(bus.window2), int'(bus.inst2[11:10]));
        return (rd_x && rx1 == rx2) || (rd_y && ry1 == rx2);
    endfunction

    function automatic bit hold_now();
        bit memop;
        memop = (bus.inst3[15:12] == 4'd0) || (bus.inst3[15:12] == 4'd1);
        return (m_mode == 1 && memop && bus.mem_busy) || (m_mode == 2 && bus.mem_busy);
    endfunction

    function automatic obs_t expect_now();
        obs_t e;
        e = '0;
        e.state     = m_mode[1:0];
        e.stall_cnt = m_stall[15:0];
        e.flush_cnt = m_flush[15:0];
        if (m_mode == 0) begin
            e.ifid_flush = 1; e.idex_flush = 1; e.memwb_flush = 1;
        end else if (m_mode == 3) begin
            e.halted = 1; e.mem_err = 1;
        end else if (hold_now()) begin
            e.memwb_flush = 1;
        end else begin
            e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1; e.exmem_we = 1;
            if (hazard()) begin
                e.pc_we = 0; e.ifid_we = 0; e.idex_flush = 1;
            end else if (bus.inst1[15:12] == 4'd4 && bus.br_taken) begin
                e.ifid_flush = 1;
            end
        end
        return e;
    endfunction

    // Model advance on each clock edge; reset returns it to boot at once.
    always @(posedge clk or posedge rst) begin
        obs_t e;
        if (rst) begin
            m_mode <= 0; m_boot_left <= BOOT_CYCLES; m_wait_n <= 0; m_stall <= 0; m_flush <= 0;
        end else begin
            e = expect_now();
`ifdef PIPE_PERF_CNT_EN
            if (bus.perf_clr) begin
                m_stall <= 0; m_flush <= 0;
            end else begin
                if ((m_mode == 1 || m_mode == 2) && !e.pc_we && m_stall < 65535) m_stall <= m_stall + 1;
                if ((m_mode == 1 || m_mode == 2) && e.ifid_flush && m_flush < 65535) m_flush <= m_flush + 1;
            end
`endif
            case (m_mode)
                0: begin
                    if (m_boot_left == 1) m_mode <= 1;
                    m_boot_left <= m_boot_left - 1;
                end
                1: if (hold_now()) begin m_mode <= 2; m_wait_n <= 0; end
                2: begin
                    if (bus.mem_busy) begin
                        if (MEM_TIMEOUT != 0 && m_wait_n + 1 == MEM_TIMEOUT) m_mode <= 3;
                        m_wait_n <= m_wait_n + 1;
                    end else begin
                        m_mode <= 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: compare the full output set with the model on the falling edge,
    // then return just after the next rising edge.
    task automatic cyc();
        obs_t got, e;
        @(negedge clk);
        e   = expect_now();
        got = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we, bus.idex_flush,
               bus.exmem_we, bus.memwb_flush, bus.halted, bus.mem_err, bus.state,
               bus.stall_cnt, bus.flush_cnt};
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL model_cmp @%0t: got %h expected %h", $time, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst1 = 16'h8000; bus.inst2 = 16'h8000; bus.inst3 = 16'h8000;
        bus.window1 = 2'd0; bus.window2 = 2'd0;
        bus.br_taken = 1'b0; bus.mem_busy = 1'b0; bus.perf_clr = 1'b0;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        // Reset values
        lit("rst_pc_we", 16'(bus.pc_we), 16'd0);
        lit("rst_ifid_flush", 16'(bus.ifid_flush), 16'd1);
        lit("rst_memwb_flush", 16'(bus.memwb_flush), 16'd1);
        lit("rst_state", 16'(bus.state), 16'd0);
        lit("rst_mem_err", 16'(bus.mem_err), 16'd0);
        lit("rst_stall_cnt", bus.stall_cnt, 16'd0);
        rst = 1'b0;

        // T1: boot for four cycles, RUN on the fifth
        for (int k = 0; k < 4; k++) begin
            #1;
            lit("boot_pc_we", 16'(bus.pc_we), 16'd0);
            lit("boot_state", 16'(bus.state), 16'd0);
            cyc();
        end
        #1;
        lit("run_pc_we", 16'(bus.pc_we), 16'd1);
        lit("run_state", 16'(bus.state), 16'd1);
        cyc();

        // T2: load to phys 1 ahead of an ALU reading phys 1
        bus.inst2 = 16'h0400; bus.inst1 = 16'h8100;
        #1;
        lit("t2_pc_we", 16'(bus.pc_we), 16'd0);
        lit("t2_ifid_we", 16'(bus.ifid_we), 16'd0);
        lit("t2_idex_flush", 16'(bus.idex_flush), 16'd1);
        cyc();
        idle();
        #1;
        lit("t2_resume_pc_we", 16'(bus.pc_we), 16'd1);
        lit("t2_stall_cnt", bus.stall_cnt, 16'(PERF * 1));
        cyc();

        // T3: window wrap, window 3 field 3 lands on phys 1
        bus.inst2 = 16'h0C00; bus.window2 = 2'd3; bus.inst1 = 16'h8100;
        #1;
        lit("t3_ifid_we", 16'(bus.ifid_we), 16'd0);
        lit("t3_idex_flush", 16'(bus.idex_flush), 16'd1);
        cyc();
        idle();
        #1;
        lit("t3_stall_cnt", bus.stall_cnt, 16'(PERF * 2));
        cyc();

        // T4: taken branch flushes; same branch behind a load stalls instead
        bus.inst1 = 16'h4000; bus.br_taken = 1'b1; bus.inst2 = 16'h8000;
        #1;
        lit("t4_ifid_flush", 16'(bus.ifid_flush), 16'd1);
        lit("t4_pc_we", 16'(bus.pc_we), 16'd1);
        cyc();
        idle();
        #1;
        lit("t4_flush_cnt", bus.flush_cnt, 16'(PERF * 1));
        bus.inst1 = 16'h4000; bus.br_taken = 1'b1; bus.inst2 = 16'h0000;
        #1;
        lit("t4b_pc_we", 16'(bus.pc_we), 16'd0);
        lit("t4b_ifid_flush", 16'(bus.ifid_flush), 16'd0);
        cyc();
        idle();
        #1;
        lit("t4b_stall_cnt", bus.stall_cnt, 16'(PERF * 3));

        // Clear wins over a simultaneous stall
        bus.inst2 = 16'h0000; bus.perf_clr = 1'b1;
        cyc();
        idle();
        #1;
        lit("clr_stall_cnt", bus.stall_cnt, 16'd0);
        lit("clr_flush_cnt", bus.flush_cnt, 16'd0);

        // T5: store in MEM with memory busy for three cycles
        bus.inst3 = 16'h1000; bus.mem_busy = 1'b1;
        #1;
        lit("t5_exmem_we", 16'(bus.exmem_we), 16'd0);
        lit("t5_memwb_flush", 16'(bus.memwb_flush), 16'd1);
        lit("t5_state_c1", 16'(bus.state), 16'd1);
        cyc();
        #1;
        lit("t5_state_c2", 16'(bus.state), 16'd2);
        lit("t5_pc_we_c2", 16'(bus.pc_we), 16'd0);
        cyc();
        cyc();
        bus.mem_busy = 1'b0; bus.inst3 = 16'h8000;
        #1;
        lit("t5_exit_state", 16'(bus.state), 16'd2);
        lit("t5_exit_pc_we", 16'(bus.pc_we), 16'd1);
        cyc();
        #1;
        lit("t5_back_state", 16'(bus.state), 16'd1);
        lit("t5_stall_cnt", bus.stall_cnt, 16'(PERF * 3));

        // T5b: busy for nine cycles trips the watchdog
        bus.inst3 = 16'h1000; bus.mem_busy = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            #1;
            lit("t5b_state", 16'(bus.state), (k == 1) ? 16'd1 : 16'd2);
            cyc();
        end
        #1;
        lit("t5b_halt_state", 16'(bus.state), 16'd3);
        lit("t5b_mem_err", 16'(bus.mem_err), 16'd1);
        lit("t5b_halted", 16'(bus.halted), 16'd1);
        lit("t5b_memwb_flush", 16'(bus.memwb_flush), 16'd0);
        bus.mem_busy = 1'b0; bus.inst3 = 16'h8000;
        cyc();
        #1;
        lit("t5b_halt_stays", 16'(bus.state), 16'd3);

        // T6: reset out of HALT
        rst = 1'b1;
        #1;
        lit("t6_state", 16'(bus.state), 16'd0);
        lit("t6_mem_err", 16'(bus.mem_err), 16'd0);
        lit("t6_halted", 16'(bus.halted), 16'd0);
        lit("t6_ifid_flush", 16'(bus.ifid_flush), 16'd1);
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        #1;
        lit("t6_rerun_state", 16'(bus.state), 16'd1);

        // T6b: reset in the middle of a memory wait
        bus.inst3 = 16'h0000; bus.mem_busy = 1'b1;
        cyc();
        #1;
        lit("t6b_wait_state", 16'(bus.state), 16'd2);
        rst = 1'b1;
        #1;
        lit("t6b_state", 16'(bus.state), 16'd0);
        lit("t6b_pc_we", 16'(bus.pc_we), 16'd0);
        lit("t6b_memwb_flush", 16'(bus.memwb_flush), 16'd1);
        cyc();
        idle();
        rst = 1'b0;
        repeat (6) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
